// File: rtl/i2s_speaker_tx_if.sv
// i2s_speaker_tx_if
//   Bundles the upstream sample inputs, the DAC pin outputs and the frame
//   request strobe of the I2S speaker transmitter.
//   master : the transmitter (consumes samples, drives DAC pins and sample_req)
//   slave  : the sample source / board side (drives samples, observes pins)
interface i2s_speaker_tx_if;
  logic [15:0] audio_in_left;   // left sample, two's complement
  logic [15:0] audio_in_right;  // right sample, two's complement
  logic        audio_mclk;      // DAC master clock, clk/4
  logic        audio_sck;       // serial bit clock, clk/16
  logic        audio_lrck;      // word select, clk/512, 0 = left
  logic        audio_sdin;      // serial data, MSB first
  logic        sample_req;      // one-clk pulse at the frame boundary

  modport master (
    input  audio_in_left, audio_in_right,
    output audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req
  );

  modport slave (
    output audio_in_left, audio_in_right,
    input  audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req
  );
endinterface

// File: rtl/i2s_speaker_tx.sv
// i2s_speaker_tx
//   Serialises 16-bit stereo samples for a CS4344-class I2S DAC. Every DAC
//   clock comes from one free-running 9-bit counter on the 100 MHz clock, so
//   all pins are plain register bits and cannot glitch.
//   Ports:
//     clk  : 100 MHz system clock
//     rst  : synchronous active-high reset
//     bus  : i2s_speaker_tx_if.master
//            audio_in_left/right in, audio_mclk/sck/lrck/sdin and
//            sample_req out
//   FORMAT_I2S = 1 : Philips I2S (MSB one SCK after the LRCK edge)
//   FORMAT_I2S = 0 : left-justified (MSB coincident with the LRCK edge)
module i2s_speaker_tx #(
  parameter bit FORMAT_I2S = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  i2s_speaker_tx_if.master   bus
);

  logic [8:0]  cnt_r;
  logic [15:0] left_buf_r;
  logic [15:0] right_buf_r;
  logic        sdin_r;
  logic        sample_req_r;

  logic [8:0]  cnt_nxt_s;
  logic [15:0] left_nxt_s;
  logic [15:0] right_nxt_s;
  logic        sdin_nxt_s;
  logic        sample_req_nxt_s;

  // Bit of the buffered words that belongs on sdin during the given slot.
  function automatic logic slot_bit(input logic [4:0]  slot,
                                    input logic [15:0] lw,
                                    input logic [15:0] rw);
    logic [4:0] idx_s;
    logic       bit_s;
    idx_s = 5'd0;
    bit_s = 1'b0;
    if (FORMAT_I2S == 1'b1) begin
      if (slot == 5'd0) begin
        // Tail of the previous right word.
        bit_s = rw[0];
      end else if (slot <= 5'd16) begin
        idx_s = 5'd16 - slot;
        bit_s = lw[idx_s[3:0]];
      end else begin
        // 32 - slot, modulo 32, gives bits 15..1 for slots 17..31.
        idx_s = 5'd0 - slot;
        bit_s = rw[idx_s[3:0]];
      end
    end else begin
      if (slot[4] == 1'b0) begin
        bit_s = lw[~slot[3:0]];
      end else begin
        bit_s = rw[~slot[3:0]];
      end
    end
    return bit_s;
  endfunction

  // Next-state values. sdin and sample_req are computed from the values the
  // counter and buffers will hold next cycle, so the registered pins line up
  // exactly with the counter they belong to.
  always_comb begin
    cnt_nxt_s = cnt_r + 9'd1;
    if (cnt_r == 9'd511) begin
      left_nxt_s = bus.audio_in_left;
    end else begin
      left_nxt_s = left_buf_r;
    end
    if (cnt_r == 9'd255) begin
      right_nxt_s = bus.audio_in_right;
    end else begin
      right_nxt_s = right_buf_r;
    end
    sdin_nxt_s       = slot_bit(cnt_nxt_s[8:4], left_nxt_s, right_nxt_s);
    sample_req_nxt_s = (cnt_nxt_s == 9'd0);
  end

  // Timing counter, sample buffers and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= 9'd0;
      left_buf_r   <= 16'd0;
      right_buf_r  <= 16'd0;
      sdin_r       <= 1'b0;
      sample_req_r <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      left_buf_r   <= left_nxt_s;
      right_buf_r  <= right_nxt_s;
      sdin_r       <= sdin_nxt_s;
      sample_req_r <= sample_req_nxt_s;
    end
  end

  // Clock pins are straight counter bits.
  assign bus.audio_mclk = cnt_r[1];
  assign bus.audio_sck  = cnt_r[3];
  assign bus.audio_lrck = cnt_r[8];
  assign bus.audio_sdin = sdin_r;
  assign bus.sample_req = sample_req_r;

endmodule

// File: tb/tb_i2s_speaker_tx.sv
// Testbench for i2s_speaker_tx: one instance per framing format, shared
// inputs. A reference frame counter predicts the clock pins; a scoreboard
// queue receives each word at its latch point and a pin-level I2S receiver
// per instance pops and compares every reconstructed word.
module tb_i2s_speaker_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] left_in = 16'd0;
  logic [15:0] right_in = 16'd0;

  i2s_speaker_tx_if if_i2s ();
  i2s_speaker_tx_if if_lj ();

  assign if_i2s.audio_in_left  = left_in;
  assign if_i2s.audio_in_right = right_in;
  assign if_lj.audio_in_left   = left_in;
  assign if_lj.audio_in_right  = right_in;

  i2s_speaker_tx #(.FORMAT_I2S(1'b1)) dut_i2s (.clk(clk), .rst(rst), .bus(if_i2s));
  i2s_speaker_tx #(.FORMAT_I2S(1'b0)) dut_lj  (.clk(clk), .rst(rst), .bus(if_lj));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference frame position and scoreboard queues ({channel, word}).
  logic [8:0]  tcnt  = 9'd0;
  bit          first = 1'b1;
  logic [16:0] q_i2s [$];
  logic [16:0] q_lj  [$];

  // Receiver state, index 0 = I2S instance, 1 = left-justified instance.
  logic [4:0]  rx_pos      [2];
  logic [15:0] rx_sr       [2];
  bit          rx_have_r   [2];
  logic        rx_prev_sck [2];
  logic        rx_prev_sd  [2];
  int          rx_words    [2];

  // Hand-built slot patterns for A5C3 / 3C5A.
  logic [15:0] vl = 16'hA5C3;
  logic [15:0] vr = 16'h3C5A;
  logic [31:0] pat_i2s;
  logic [31:0] pat_lj;
  bit          pat_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t cnt=%0d)", name, act, exp, $time, tcnt);
    end
  endtask

  task automatic sb_pop(input int id, input logic [16:0] got);
    logic [16:0] exp;
    if (id == 0) begin
      if (q_i2s.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL word_i2s: got %h expected none (queue empty)", got);
        return;
      end
      exp = q_i2s.pop_front();
      check("word_i2s", {15'd0, got}, {15'd0, exp});
    end else begin
      if (q_lj.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL word_lj: got %h expected none (queue empty)", got);
        return;
      end
      exp = q_lj.pop_front();
      check("word_lj", {15'd0, got}, {15'd0, exp});
    end
    rx_words[id]++;
  endtask

  // One pin-level receiver step: shift on SCK rise, emit completed words.
  task automatic rx_step(input int id, input logic sck, input logic sd);
    logic [4:0]  p;
    logic [15:0] w;
    bit          emit_l;
    bit          emit_r;
    if (sck === 1'b1 && rx_prev_sck[id] === 1'b0) begin
      p = rx_pos[id];
      w = {rx_sr[id][14:0], sd};
      rx_sr[id] = w;
      if (id == 0) begin
        emit_l = (p == 5'd16);
        emit_r = (p == 5'd0) && rx_have_r[id];
        if (p == 5'd31) rx_have_r[id] = 1'b1;
        if (pat_en) check("pattern_i2s", {31'd0, sd}, {31'd0, pat_i2s[5'd31 - p]});
      end else begin
        emit_l = (p == 5'd15);
        emit_r = (p == 5'd31);
        if (pat_en) check("pattern_lj", {31'd0, sd}, {31'd0, pat_lj[5'd31 - p]});
      end
      if (emit_l) sb_pop(id, {1'b0, w});
      if (emit_r) sb_pop(id, {1'b1, w});
      rx_pos[id] = p + 5'd1;
    end
    rx_prev_sck[id] = sck;
  endtask

  // Reference model at the active edge: counter and latch-point pushes.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        tcnt  = 9'd0;
        first = 1'b1;
        q_i2s.delete();
        q_lj.delete();
        q_i2s.push_back(17'h0_0000);
        q_lj.push_back(17'h0_0000);
      end else begin
        first = 1'b0;
        if (tcnt == 9'd255) begin
          q_i2s.push_back({1'b1, right_in});
          q_lj.push_back({1'b1, right_in});
        end
        if (tcnt == 9'd511) begin
          q_i2s.push_back({1'b0, left_in});
          q_lj.push_back({1'b0, left_in});
        end
        tcnt = tcnt + 9'd1;
      end
    end
  end

  // Monitor on the falling edge: pin timing, sdin stability, receivers.
  initial begin
    logic [3:0] exp_pins;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          rx_pos[i]      = 5'd0;
          rx_sr[i]       = 16'd0;
          rx_have_r[i]   = 1'b0;
          rx_prev_sck[i] = 1'b0;
        end
      end else begin
        exp_pins = {tcnt[1], tcnt[3], tcnt[8], (tcnt == 9'd0) && !first};
        check("pins_i2s", {28'd0, if_i2s.audio_mclk, if_i2s.audio_sck, if_i2s.audio_lrck, if_i2s.sample_req}, {28'd0, exp_pins});
        check("pins_lj", {28'd0, if_lj.audio_mclk, if_lj.audio_sck, if_lj.audio_lrck, if_lj.sample_req}, {28'd0, exp_pins});
        if (first) begin
          check("sdin_reset_i2s", {31'd0, if_i2s.audio_sdin}, 32'd0);
          check("sdin_reset_lj", {31'd0, if_lj.audio_sdin}, 32'd0);
        end else if (tcnt[3:0] != 4'd0) begin
          check("sdin_stable_i2s", {31'd0, if_i2s.audio_sdin}, {31'd0, rx_prev_sd[0]});
          check("sdin_stable_lj", {31'd0, if_lj.audio_sdin}, {31'd0, rx_prev_sd[1]});
        end
        rx_step(0, if_i2s.audio_sck, if_i2s.audio_sdin);
        rx_step(1, if_lj.audio_sck, if_lj.audio_sdin);
      end
      rx_prev_sd[0] = if_i2s.audio_sdin;
      rx_prev_sd[1] = if_lj.audio_sdin;
    end
  end

  // Advance to the cycle whose counter equals v (bounded by one frame).
  task automatic wait_cnt(input logic [8:0] v);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (tcnt != v && n < 600);
  endtask

  // Directed stimulus.
  initial begin
    int pt;
    pat_i2s = {vr[0], vl, vr[15:1]};
    pat_lj  = {vl, vr};
    for (int i = 0; i < 2; i++) rx_words[i] = 0;

    // Reset for 3 clk with the constant pattern already on the inputs.
    left_in  = vl;
    right_in = vr;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Frame 0 after reset: zero left word; then two frames of fixed pattern.
    wait_cnt(9'd511);
    wait_cnt(9'd0);
    pat_en = 1'b1;
    wait_cnt(9'd511);
    wait_cnt(9'd511);
    pat_en = 1'b0;

    // Mid-word input changes: 7FFF in flight, 8000 only from the next latch.
    wait_cnt(9'd0);
    left_in  = 16'h7FFF;
    right_in = 16'h7FFF;
    wait_cnt(9'd100);
    wait_cnt(9'd100);
    left_in = 16'h8000;
    wait_cnt(9'd300);
    right_in = 16'h8000;
    wait_cnt(9'd0);
    wait_cnt(9'd0);

    // Reset pulse mid-frame with nonzero inputs.
    left_in  = 16'h1234;
    right_in = 16'h5678;
    wait_cnt(9'd200);
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    wait_cnt(9'd0);
    wait_cnt(9'd0);

    // Random sample pairs, one change per frame at a random point.
    for (int f = 0; f < 64; f++) begin
      wait_cnt(9'd0);
      pt = $urandom_range(1, 510);
      wait_cnt(pt[8:0]);
      left_in  = 16'($urandom);
      right_in = 16'($urandom);
    end
    wait_cnt(9'd0);
    wait_cnt(9'd0);
    wait_cnt(9'd300);

    check("drain_i2s", {31'd0, q_i2s.size() <= 3}, 32'd1);
    check("drain_lj", {31'd0, q_lj.size() <= 3}, 32'd1);
    check("words_i2s", {31'd0, rx_words[0] >= 140}, 32'd1);
    check("words_lj", {31'd0, rx_words[1] >= 140}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
